// File: rtl/run_arb_pkg.sv
// Shared types for the run arbiter: arbiter FSM states, run-detector encodings
// and the detector transition function.
package run_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT  = 2'b01,
    REPORT = 2'b10
  } arb_state_e;

  typedef enum logic [1:0] {
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } det_state_e;

  // One step of the two-consecutive-ones detector; unknown encodings fall back to S1.
  function automatic det_state_e det_next(det_state_e s, logic x);
    det_state_e n;
    case (s)
      S1:      n = x ? S2 : S1;
      S2:      n = x ? S3 : S1;
      S3:      n = x ? S3 : S1;
      default: n = S1;
    endcase
    return n;
  endfunction

  function automatic logic det_legal(det_state_e s);
    return (s == S1) || (s == S2) || (s == S3);
  endfunction

endpackage

// File: rtl/run_detector.sv
// Moore detector for two or more consecutive ones, with a synchronous clear used
// to start every frame from S1.
module run_detector
  import run_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic x,
  output logic z,
  output logic hit_next
);

  det_state_e state_q, state_d, step;

  assign step = det_next(state_q, x);

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S1;
    end else if (en) begin
      state_d = step;
    end else if (!det_legal(state_q)) begin
      state_d = S1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S1;
    end else begin
      state_q <= state_d;
    end
  end

  assign z        = (state_q == S3);
  assign hit_next = en && (step == S3);

endmodule

// File: rtl/run_arbiter.sv
// Round-robin arbiter sharing one run detector among N_REQ serial requesters; each
// grant samples FRAME_LEN bits and reports hit, run count and requester id.
module run_arbiter
  import run_arb_pkg::*;
#(
  parameter int unsigned  N_REQ     = 4,
  parameter int unsigned  FRAME_LEN = 8,
  localparam int unsigned ID_W      = $clog2(N_REQ),
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   x_in,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               res_valid,
  output logic [ID_W-1:0]    res_id,
  output logic               res_hit,
  output logic [CNT_W-1:0]   res_count
);

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(FRAME_LEN - 1);
  localparam logic [ID_W-1:0]  LastId  = ID_W'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic             res_hit_q, res_hit_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;

  logic             found;
  logic [ID_W-1:0]  pick;
  logic [ID_W-1:0]  idx;

  logic det_clr, det_en, det_x, det_z, det_hit;

  // First set request at or above ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = ID_W'((32'(ptr_q) + i) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    res_id_d    = res_id_q;
    res_hit_d   = res_hit_q;
    res_count_d = res_count_q;
    det_clr     = 1'b0;
    det_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          win_d   = pick;
          ptr_d   = (pick == LastId) ? '0 : pick + ID_W'(1);
          cnt_d   = '0;
          acc_d   = '0;
          det_clr = 1'b1;
        end
      end
      GRANT: begin
        det_en = 1'b1;
        acc_d  = acc_q + CNT_W'(det_hit);
        if (cnt_q == LastBit) begin
          // Results latch on the final sample so they are stable throughout REPORT.
          state_d     = REPORT;
          res_id_d    = win_q;
          res_count_d = acc_d;
          res_hit_d   = (acc_d != '0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      res_id_q    <= '0;
      res_hit_q   <= 1'b0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      res_id_q    <= res_id_d;
      res_hit_q   <= res_hit_d;
      res_count_q <= res_count_d;
    end
  end

  assign det_x = x_in[win_q];

  run_detector u_det (
    .clk      (clk),
    .rst      (rst),
    .clr      (det_clr),
    .en       (det_en),
    .x        (det_x),
    .z        (det_z),
    .hit_next (det_hit)
  );

  // The detector sitting in S3 mid-frame implies a detection was already counted.
  always_ff @(posedge clk) begin
    if (!rst && state_q == GRANT && det_z) begin
      assert (acc_q != '0);
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q == GRANT) begin
      gnt[win_q] = 1'b1;
    end
  end

  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == REPORT);
  assign res_id    = res_id_q;
  assign res_hit   = res_hit_q;
  assign res_count = res_count_q;

endmodule

// File: tb/tb_run_arbiter.sv
// Directed bench for run_arbiter (N_REQ=4, FRAME_LEN=8): frame table plus a
// reset-mid-frame sequence.
module tb_run_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] x_in;
  logic [3:0] gnt;
  logic       busy;
  logic       res_valid;
  logic [1:0] res_id;
  logic       res_hit;
  logic [2:0] res_count;

  run_arbiter #(
    .N_REQ     (4),
    .FRAME_LEN (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .x_in      (x_in),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_hit   (res_hit),
    .res_count (res_count)
  );

  typedef struct {
    logic [3:0] req;
    logic [0:7] bits;    // bits[0] is sampled first
    int         drop_k;  // GRANT cycle at which req is released; 8 keeps it held
    logic [1:0] exp_id;
    logic       exp_hit;
    logic [2:0] exp_cnt;
  } vec_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   start_cyc [11];
  vec_t vecs [10];
  vec_t post;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered at the negedge of an IDLE cycle; returns at the negedge of the IDLE
  // cycle following REPORT.
  task automatic run_frame(input vec_t v, input int idx);
    logic [3:0] oh;
    oh  = 4'b0001 << v.exp_id;
    req = v.req;
    chk($sformatf("f%0d idle busy", idx), {31'b0, busy}, 32'd0);
    chk($sformatf("f%0d idle gnt", idx), {28'b0, gnt}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == v.drop_k) req = 4'b0000;
      if (k == 0) start_cyc[idx] = cyc;
      x_in = {4{~v.bits[k]}};
      x_in[v.exp_id] = v.bits[k];
      chk($sformatf("f%0d k%0d gnt", idx, k), {28'b0, gnt}, {28'b0, oh});
      chk($sformatf("f%0d k%0d busy", idx, k), {31'b0, busy}, 32'd1);
      chk($sformatf("f%0d k%0d res_valid", idx, k), {31'b0, res_valid}, 32'd0);
    end
    @(negedge clk);
    chk($sformatf("f%0d report valid", idx), {31'b0, res_valid}, 32'd1);
    chk($sformatf("f%0d report gnt", idx), {28'b0, gnt}, 32'd0);
    chk($sformatf("f%0d report busy", idx), {31'b0, busy}, 32'd1);
    chk($sformatf("f%0d report id", idx), {30'b0, res_id}, {30'b0, v.exp_id});
    chk($sformatf("f%0d report hit", idx), {31'b0, res_hit}, {31'b0, v.exp_hit});
    chk($sformatf("f%0d report count", idx), {29'b0, res_count}, {29'b0, v.exp_cnt});
    @(negedge clk);
    chk($sformatf("f%0d after valid", idx), {31'b0, res_valid}, 32'd0);
    chk($sformatf("f%0d after busy", idx), {31'b0, busy}, 32'd0);
    chk($sformatf("f%0d hold count", idx), {29'b0, res_count}, {29'b0, v.exp_cnt});
    chk($sformatf("f%0d hold id", idx), {30'b0, res_id}, {30'b0, v.exp_id});
  endtask

  initial begin
    vecs[0] = '{4'b1111, 8'b00110000, 8, 2'd0, 1'b1, 3'd1};
    vecs[1] = '{4'b1111, 8'b11100111, 8, 2'd1, 1'b1, 3'd4};
    vecs[2] = '{4'b1111, 8'b00000000, 8, 2'd2, 1'b0, 3'd0};
    vecs[3] = '{4'b1111, 8'b01010101, 8, 2'd3, 1'b0, 3'd0};
    vecs[4] = '{4'b1111, 8'b11111110, 0, 2'd0, 1'b1, 3'd6};
    vecs[5] = '{4'b0001, 8'b11111111, 0, 2'd0, 1'b1, 3'd7};
    vecs[6] = '{4'b0010, 8'b10101010, 0, 2'd1, 1'b0, 3'd0};
    vecs[7] = '{4'b0100, 8'b11011001, 0, 2'd2, 1'b1, 3'd2};
    vecs[8] = '{4'b0100, 8'b10000000, 0, 2'd2, 1'b0, 3'd0};
    vecs[9] = '{4'b1000, 8'b00011011, 2, 2'd3, 1'b1, 3'd2};
    post    = '{4'b1111, 8'b11000000, 0, 2'd0, 1'b1, 3'd1};

    rst  = 1'b1;
    req  = 4'b0000;
    x_in = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset gnt", {28'b0, gnt}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset res_valid", {31'b0, res_valid}, 32'd0);
    chk("reset res_id", {30'b0, res_id}, 32'd0);
    chk("reset res_hit", {31'b0, res_hit}, 32'd0);
    chk("reset res_count", {29'b0, res_count}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_frame(vecs[i], i);
    end

    // Held req=1111: frames back to back, one arbitration and one report cycle each.
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("spacing %0d", i), start_cyc[i] - start_cyc[i-1], 32'd10);
    end

    // Reset on the third GRANT cycle of a frame for requester 2.
    req  = 4'b0100;
    x_in = 4'b1111;
    @(negedge clk);
    chk("abort gnt k0", {28'b0, gnt}, 32'b0100);
    @(negedge clk);
    @(negedge clk);
    chk("abort gnt k2", {28'b0, gnt}, 32'b0100);
    rst = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    chk("abort gnt", {28'b0, gnt}, 32'd0);
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort res_valid", {31'b0, res_valid}, 32'd0);
    chk("abort res_id", {30'b0, res_id}, 32'd0);
    chk("abort res_hit", {31'b0, res_hit}, 32'd0);
    chk("abort res_count", {29'b0, res_count}, 32'd0);
    run_frame(post, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
